jtpinpon_gfx_arb: RTL
=====================

Name: jtpinpon_gfx_arb

Overview:
- Arbitrates the single 16-bit graphics ROM (SDRAM) read port between the char tile fetcher and the object (sprite) line fetcher.
- Sits between both video layers and the SDRAM slot.
- Holds one latched word per requester, with an ok flag that stays valid while the requester's address is unchanged.
- Char has raster-critical priority. A starvation guard and a timeout watchdog keep the object fetcher progressing.

Parameters:
CHAR_AW, 12, char fetcher address width (words)
OBJ_AW, 13, object fetcher address width (words)
STARVE_MAX, 3, consecutive char grants allowed while obj is pending before obj is forced
TOUT, 63, cycles in BUSY without rom_ok before the request is reissued

Ports:
clk  in  1  system clock, 48 MHz
rst  in  1  reset, asynchronous, active-high
char_cs  in  1  char fetch enable
char_addr  in  12  char word address
char_data  out  16  latched char word
char_ok  out  1  char_data valid for the current char_addr
obj_cs  in  1  object fetch enable
obj_addr  in  13  object word address
obj_data  out  16  latched object word
obj_ok  out  1  obj_data valid for the current obj_addr
rom_cs  out  1  SDRAM read request
rom_addr  out  14  SDRAM word address
rom_data  in  16  SDRAM read data
rom_ok  in  1  SDRAM data valid for the presented address

Behaviour:
- Reset values (asynchronous on rst): all registered outputs 0, state IDLE, starve counter 0, timeout counter 0, both valid flags 0. rom_cs is 0 within the reset assertion, including mid-fetch.
- Stored tags: lat_c (12b) and lat_o (13b). Valid flags: val_c, val_o.
- Ok outputs are combinational:
  - char_ok = char_cs & val_c & (char_addr == lat_c)
  - obj_ok = obj_cs & val_o & (obj_addr == lat_o)
- Pending requests:
  - pend_c = char_cs & ~char_ok
  - pend_o = obj_cs & ~obj_ok
- Address map:
  - char: rom_addr = {2'b00, char_addr}
  - obj: rom_addr = {1'b1, obj_addr}
- State IDLE:
  - No pending request: rom_cs = 0 and stay in IDLE.
  - Grant rule: if pend_c & ~(pend_o & starve == STARVE_MAX), grant char; otherwise, if pend_o, grant obj.
  - On grant: register rom_addr and the grant id, capture the requester address into a fetch tag, set rom_cs = 1, clear the timeout counter, and go to BUSY on the next edge.
- Starve counter:
  - Increments on each char grant made while pend_o is high, saturating at STARVE_MAX.
  - Clears on any obj grant.
  - Clears on a char grant made while pend_o is low.
- State BUSY:
  - rom_ok is ignored in the first BUSY cycle (SDRAM ok lags the address by one cycle). It is sampled from the second BUSY cycle on.
  - On a sampled rom_ok:
    - Write rom_data into the granted data register, load the tag from the fetch tag, and set the valid flag.
    - Drop rom_cs and return to IDLE.
    - Total latency: grant edge to ok = SDRAM latency + 1 cycle.
  - Timeout: if the counter reaches TOUT with no rom_ok, drop rom_cs for one cycle, return to IDLE and re-arbitrate. Data and tags are left unchanged.
- Address change mid-fetch:
  - The fetch completes and stores the old tag, so the compare fails and the ok output stays low.
  - The requester is pending again and is re-arbitrated in the next IDLE cycle.
  - rom_addr never changes while rom_cs = 1.
- Requester cs deasserted mid-fetch: the fetch still completes and updates the stored word. No abort.
- Back-to-back requests: minimum spacing is one IDLE cycle between fetches.
- Data registers hold their value until overwritten. A valid flag clears only on reset.

Test Plan:
1. Char only, addr 0x123, SDRAM latency 3 → rom_addr = 0x0123, rom_cs for 4 cycles; char_data = rom_data (e.g. 0xA55A); char_ok rises 1 cycle after rom_ok and stays high while addr = 0x123.
2. Both pending at once, obj addr 0x1ABC → char granted first, obj next with rom_addr = 0x3ABC; obj_ok rises and char_ok stays high.
3. Char re-requests a new address each fetch while obj is pending → obj granted after exactly 3 consecutive char grants; starve counter returns to 0.
4. char_addr changes from 0x010 to 0x011 during BUSY → char_ok stays 0 after completion; second fetch at 0x0011 follows after 1 IDLE cycle; then ok = 1.
5. rom_ok held low → rom_cs drops at cycle TOUT (63) for 1 cycle, same address reissued; char_data unchanged.
6. rst pulsed mid-BUSY → rom_cs, both ok outputs and both data outputs read 0 while rst is high; after release, a pending char request is re-granted from IDLE.

Source files
------------

// File: rtl/jtpinpon_gfx_arb_if.sv
// Graphics ROM arbiter bus: char fetcher, object fetcher and SDRAM slot.
// master = arbiter view, slave = fetchers/SDRAM side view.
interface jtpinpon_gfx_arb_if #(
   parameter int CHAR_AW = 12,
   parameter int OBJ_AW  = 13
);
   logic                char_cs;
   logic [CHAR_AW-1:0]  char_addr;
   logic [15:0]         char_data;
   logic                char_ok;
   logic                obj_cs;
   logic [OBJ_AW-1:0]   obj_addr;
   logic [15:0]         obj_data;
   logic                obj_ok;
   logic                rom_cs;
   logic [OBJ_AW:0]     rom_addr;
   logic [15:0]         rom_data;
   logic                rom_ok;

   modport master (
      input  char_cs, char_addr, obj_cs, obj_addr, rom_data, rom_ok,
      output char_data, char_ok, obj_data, obj_ok, rom_cs, rom_addr
   );

   modport slave (
      output char_cs, char_addr, obj_cs, obj_addr, rom_data, rom_ok,
      input  char_data, char_ok, obj_data, obj_ok, rom_cs, rom_addr
   );
endinterface

// File: rtl/jtpinpon_gfx_arb.sv
// Shares the graphics ROM read port between the char tile fetcher and the
// object line fetcher. Char wins by default; obj is forced through after
// STARVE_MAX consecutive char grants, and a stuck slot is reissued on timeout.
module jtpinpon_gfx_arb #(
   parameter int CHAR_AW    = 12,
   parameter int OBJ_AW     = 13,
   parameter int STARVE_MAX = 3,
   parameter int TOUT       = 63
) (
   input  logic               clk,
   input  logic               rst,
   jtpinpon_gfx_arb_if.master bus
);
   localparam int RAW = OBJ_AW + 1;
   localparam int SW  = $clog2(STARVE_MAX + 1);
   localparam int TW  = $clog2(TOUT + 1);

   typedef enum logic { IDLE, BUSY } st_t;

   st_t                st;
   logic               rom_cs;
   logic [RAW-1:0]     rom_addr;
   logic               gnt_o;      // current fetch belongs to obj
   logic               first;      // first BUSY cycle, rom_ok still stale
   logic [OBJ_AW-1:0]  ftag;       // requester address captured at grant
   logic [CHAR_AW-1:0] lat_c;
   logic [OBJ_AW-1:0]  lat_o;
   logic               val_c, val_o;
   logic [15:0]        data_c, data_o;
   logic [SW-1:0]      starve;
   logic [TW-1:0]      tout_cnt;

   logic               char_ok, obj_ok, pend_c, pend_o, take_c, take_o;

   assign char_ok = bus.char_cs & val_c & (bus.char_addr == lat_c);
   assign obj_ok  = bus.obj_cs  & val_o & (bus.obj_addr  == lat_o);
   assign pend_c  = bus.char_cs & ~char_ok;
   assign pend_o  = bus.obj_cs  & ~obj_ok;
   // char keeps priority unless obj has already waited out STARVE_MAX grants
   assign take_c  = pend_c & ~(pend_o & (starve == SW'(STARVE_MAX)));
   assign take_o  = ~take_c & pend_o;

   assign bus.char_ok   = char_ok;
   assign bus.obj_ok    = obj_ok;
   assign bus.char_data = data_c;
   assign bus.obj_data  = data_o;
   assign bus.rom_cs    = rom_cs;
   assign bus.rom_addr  = rom_addr;

   // Arbitration FSM: grant in IDLE, hold the slot in BUSY until data or timeout
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         st       <= IDLE;
         rom_cs   <= 1'b0;
         rom_addr <= '0;
         gnt_o    <= 1'b0;
         first    <= 1'b0;
         ftag     <= '0;
         lat_c    <= '0;
         lat_o    <= '0;
         val_c    <= 1'b0;
         val_o    <= 1'b0;
         data_c   <= '0;
         data_o   <= '0;
         starve   <= '0;
         tout_cnt <= '0;
      end else begin
         case (st)
            IDLE: begin
               if (take_c || take_o) begin
                  rom_cs   <= 1'b1;
                  rom_addr <= take_c ? {{(RAW-CHAR_AW){1'b0}}, bus.char_addr}
                                     : {1'b1, bus.obj_addr};
                  ftag     <= take_c ? OBJ_AW'(bus.char_addr) : bus.obj_addr;
                  gnt_o    <= ~take_c;
                  first    <= 1'b1;
                  tout_cnt <= '0;
                  st       <= BUSY;
                  if (take_c && pend_o)
                     starve <= (starve == SW'(STARVE_MAX)) ? starve : starve + SW'(1);
                  else
                     starve <= '0;
               end
            end
            BUSY: begin
               first <= 1'b0;
               if (!first && bus.rom_ok) begin
                  if (gnt_o) begin
                     data_o <= bus.rom_data;
                     lat_o  <= ftag;
                     val_o  <= 1'b1;
                  end else begin
                     data_c <= bus.rom_data;
                     lat_c  <= ftag[CHAR_AW-1:0];
                     val_c  <= 1'b1;
                  end
                  rom_cs <= 1'b0;
                  st     <= IDLE;
               end else if (tout_cnt == TW'(TOUT - 1)) begin
                  // give the slot up for a cycle and re-arbitrate
                  rom_cs <= 1'b0;
                  st     <= IDLE;
               end else begin
                  tout_cnt <= tout_cnt + TW'(1);
               end
            end
            default: st <= IDLE;
         endcase
      end
   end
endmodule
